// File: rtl/rr_sel_pkg.sv
// rtl/rr_sel_pkg.sv - shared constants, state type and index helper for the round-robin selector
package rr_sel_pkg;

  localparam int N_REQ = 32;
  localparam int IDX_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // N_REQ is a power of two, so the natural IDX_W-bit wrap is the modulo.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set request at or after ptr, with optional single-bit mask
module rr_pick
  import rr_sel_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             mask_en,
  input  logic [IDX_W-1:0] mask_idx,
  output logic             found,
  output logic [IDX_W-1:0] win_idx
);

  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] rot;

  always_comb begin
    masked = req;
    if (mask_en) begin
      masked[mask_idx] = 1'b0;
    end
    // Rotate so bit 0 of rot is request index ptr; the lowest set bit wins.
    rot = N_REQ'({masked, masked} >> ptr);
    found   = 1'b0;
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found   = 1'b1;
        win_idx = ptr + IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// rtl/rr_sel_arbiter.sv - round-robin arbiter presenting one winner index under a valid/ready handshake
module rr_sel_arbiter
  import rr_sel_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic             gnt_valid,
  input  logic             gnt_ready,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             hs;
  logic [IDX_W-1:0] pick_ptr;
  logic             found;
  logic [IDX_W-1:0] win_idx;

  assign hs = (state == GRANT) && gnt_ready;

  // On a handshake the pick already sees the advanced pointer and skips the
  // index just served, giving back-to-back grants without a bubble.
  assign pick_ptr = hs ? next_idx(idx) : ptr;

  rr_pick u_pick (
    .req      (req),
    .ptr      (pick_ptr),
    .mask_en  (hs),
    .mask_idx (idx),
    .found    (found),
    .win_idx  (win_idx)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx;
    if (state == IDLE) begin
      if (found) begin
        idx_nxt   = win_idx;
        state_nxt = GRANT;
      end
    end else if (gnt_ready) begin
      ptr_nxt = next_idx(idx);
      if (found) begin
        idx_nxt = win_idx;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      idx   <= idx_nxt;
    end
  end

  assign gnt_valid = (state == GRANT);
  assign busy      = (state == GRANT);
  assign gnt_idx   = idx;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb/tb_rr_sel_arbiter.sv - directed vector table plus randomized run against a reference model
module tb_rr_sel_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] req = '0;
  logic        gnt_ready = 1'b0;
  logic        gnt_valid;
  logic [4:0]  gnt_idx;
  logic        busy;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  rr_sel_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt_valid (gnt_valid),
    .gnt_ready (gnt_ready),
    .gnt_idx   (gnt_idx),
    .busy      (busy)
  );

  typedef struct {
    logic        rst;
    logic [31:0] rq;
    logic        rdy;
    logic        ev;
    logic [4:0]  ei;
  } vec_t;

  vec_t vecs[$];

  // Reference: a pending grant and a rotating pointer, picked by scanning
  // indices ptr, ptr+1, ... modulo 32.
  bit m_valid;
  int m_idx;
  int m_ptr;

  function automatic bit mpick(input logic [31:0] q, input int p, input int m, output int w);
    for (int k = 0; k < 32; k++) begin
      int j;
      j = (p + k) % 32;
      if (q[j] && j != m) begin
        w = j;
        return 1'b1;
      end
    end
    w = 0;
    return 1'b0;
  endfunction

  function automatic void model_update(input logic r, input logic [31:0] q, input logic y);
    int w;
    if (!r) begin
      m_valid = 1'b0;
      m_idx   = 0;
      m_ptr   = 0;
    end else if (!m_valid) begin
      if (mpick(q, m_ptr, -1, w)) begin
        m_valid = 1'b1;
        m_idx   = w;
      end
    end else if (y) begin
      m_ptr = (m_idx + 1) % 32;
      if (mpick(q, m_ptr, m_idx, w)) m_idx = w;
      else m_valid = 1'b0;
    end
  endfunction

  function automatic void add(input logic r, input logic [31:0] q, input logic y,
                              input logic ev, input int ei);
    vec_t v;
    v.rst = r; v.rq = q; v.rdy = y; v.ev = ev; v.ei = 5'(ei);
    vecs.push_back(v);
  endfunction

  task automatic step(input logic r, input logic [31:0] q, input logic y);
    rst_n = r;
    req = q;
    gnt_ready = y;
    @(posedge clk);
    model_update(r, q, y);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Idle after reset.
    add(1'b0, 32'h0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 10; i++) add(1'b1, 32'h0, 1'b0, 1'b0, 0);
    // 0x14 from ptr 0: 2, 4, then 2 again once ptr has moved to 5.
    add(1'b1, 32'h0000_0014, 1'b1, 1'b1, 2);
    add(1'b1, 32'h0000_0014, 1'b1, 1'b1, 4);
    add(1'b1, 32'h0000_0014, 1'b1, 1'b1, 2);
    add(1'b1, 32'h0, 1'b1, 1'b0, 2);
    // Full sweep with the 31 -> 0 wrap.
    add(1'b0, 32'h0, 1'b0, 1'b0, 0);
    for (int k = 0; k < 33; k++) add(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, k % 32);
    add(1'b1, 32'h0, 1'b1, 1'b0, 0);
    // Sticky grant 7 while req moves to 3.
    add(1'b1, 32'h1 << 7, 1'b0, 1'b1, 7);
    for (int k = 0; k < 5; k++) add(1'b1, 32'h1 << 3, 1'b0, 1'b1, 7);
    add(1'b1, 32'h1 << 3, 1'b1, 1'b1, 3);
    add(1'b1, 32'h0, 1'b1, 1'b0, 3);
    // Lone requester skipped once after each handshake.
    for (int k = 0; k < 2; k++) begin
      add(1'b1, 32'h1 << 9, 1'b1, 1'b1, 9);
      add(1'b1, 32'h1 << 9, 1'b1, 1'b0, 9);
    end
    // Reset drops a pending grant and returns ptr to 0.
    add(1'b1, 32'h1 << 5, 1'b0, 1'b1, 5);
    add(1'b0, 32'h1 << 5, 1'b0, 1'b0, 0);
    add(1'b1, 32'h8000_0001, 1'b1, 1'b1, 0);
    add(1'b1, 32'h8000_0001, 1'b1, 1'b1, 31);
    add(1'b1, 32'h0, 1'b1, 1'b0, 31);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].rq, vecs[i].rdy);
      check($sformatf("vec%0d_valid", i), 32'(gnt_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].ev));
      check($sformatf("vec%0d_idx", i), 32'(gnt_idx), 32'(vecs[i].ei));
    end

    step(1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      logic        r;
      logic [31:0] q;
      logic        y;
      r = ($urandom_range(0, 149) != 0);
      case ($urandom_range(0, 3))
        0:       q = 32'h0;
        1:       q = 32'h1 << $urandom_range(0, 31);
        2:       q = $urandom & $urandom & $urandom;
        default: q = $urandom;
      endcase
      y = ($urandom_range(0, 3) != 0);
      step(r, q, y);
      check($sformatf("rnd%0d_valid", c), 32'(gnt_valid), 32'(m_valid));
      check($sformatf("rnd%0d_busy", c), 32'(busy), 32'(m_valid));
      check($sformatf("rnd%0d_idx", c), 32'(gnt_idx), 32'(m_idx));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
